jk_cmd_scheduler: RTL

- Owns a bank of NUM_CELLS JK flip-flop cells and shares it between NUM_REQ requesters.
- Each requester issues hold/reset/set/toggle commands addressed to one cell over a valid/ready handshake.
- Round-robin arbitration grants one command per cycle. An optional lock lets one requester issue a bounded burst.
- Granted commands pass through one pipeline register, then drive J/K of the addressed cell.

---
 rtl/jk_sched_pkg.sv | 21 ++
 rtl/jk_cell.sv | 33 +++
 rtl/jk_cmd_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/jk_sched_pkg.sv
// ============================================================================
// jk_sched_pkg : shared command encodings and FSM state type for jk_cmd_scheduler
// Revision     : 1.0
// ============================================================================
`default_nettype none

package jk_sched_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic [0:0] {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
// jk_cell  : single JK flip-flop, updates only when en is high
// Revision : 1.0
// ============================================================================
`default_nettype none

module jk_cell
  import jk_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        CMD_RST: q <= 1'b0;
        CMD_SET: q <= 1'b1;
        CMD_TGL: q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_cmd_scheduler.sv
// ============================================================================
// jk_cmd_scheduler : round-robin/burst-lock arbiter feeding a bank of JK cells
// Revision         : 1.0
// ============================================================================
`default_nettype none

module jk_cmd_scheduler
  import jk_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_CELLS = 8,
  parameter  int MAX_BURST = 4,
  localparam int ADDR_W    = $clog2(NUM_CELLS),
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [2*NUM_REQ-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_CELLS-1:0]      q,
  output logic                      app_valid,
  output logic [ID_W-1:0]           app_id,
  output logic                      oob_err
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  sched_state_t     state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic               arb_en;
  logic [ID_W-1:0]    scan_base;
  logic [ID_W-1:0]    scan_idx;

  logic               stage_valid;
  logic [ID_W-1:0]    stage_id;
  logic [1:0]         stage_cmd;
  logic [ADDR_W-1:0]  stage_addr;
  logic [NUM_CELLS-1:0] cell_en;

  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Arbitration and next-state: a locked owner that drops valid releases in
  // the same cycle, so the FREE scan below also serves that release path.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    arb_en    = 1'b0;
    scan_base = rr_ptr;
    scan_idx  = '0;

    if (state == LOCKED) begin
      if (req_valid[owner]) begin
        grant_any = 1'b1;
        grant_id  = owner;
        if (req_lock[owner] && (int'(burst_cnt) + 1 < MAX_BURST)) begin
          burst_nxt = burst_cnt + 1'b1;
        end else begin
          state_nxt = FREE;
          rr_nxt    = inc_id(owner);
          burst_nxt = '0;
        end
      end else begin
        arb_en    = 1'b1;
        scan_base = inc_id(owner);
        state_nxt = FREE;
        rr_nxt    = inc_id(owner);
        burst_nxt = '0;
      end
    end else begin
      arb_en = 1'b1;
    end

    if (arb_en) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        scan_idx = ID_W'((int'(scan_base) + off) % NUM_REQ);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_id  = scan_idx;
        end
      end
      if (grant_any) begin
        if (req_lock[grant_id]) begin
          state_nxt = LOCKED;
          owner_nxt = grant_id;
          burst_nxt = CNT_W'(1);
        end else begin
          state_nxt = FREE;
          rr_nxt    = inc_id(grant_id);
        end
      end
    end

    if (grant_any) grant[grant_id] = 1'b1;

    if (reset) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FREE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Stage register: id/cmd/addr hold their last values while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_id    <= '0;
      stage_cmd   <= CMD_HOLD;
      stage_addr  <= '0;
    end else begin
      stage_valid <= grant_any;
      if (grant_any) begin
        stage_id   <= grant_id;
        stage_cmd  <= req_cmd[2*int'(grant_id) +: 2];
        stage_addr <= req_addr[ADDR_W*int'(grant_id) +: ADDR_W];
      end
    end
  end

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    localparam logic [ADDR_W-1:0] C_ADDR = ADDR_W'(c);

    assign cell_en[c] = stage_valid && (stage_addr == C_ADDR);

    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    (cell_en[c]),
      .j     (stage_cmd[1]),
      .k     (stage_cmd[0]),
      .q     (q[c])
    );
  end

  assign app_valid = stage_valid;
  assign app_id    = stage_id;
  assign oob_err   = stage_valid && !(|cell_en);

endmodule

`default_nettype wire
